// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, status bit
// positions and the address-region decode.
package dmem_pkg;

   // MMIO word offsets, counted down from the top of the address space
   localparam int unsigned CYCLE_OFS  = 4;
   localparam int unsigned TXDATA_OFS = 3;
   localparam int unsigned STATUS_OFS = 2;
   localparam int unsigned RSVD_OFS   = 1;

   localparam int unsigned ST_FULL  = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_OVF   = 2;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_CYCLE,
      REG_TXDATA,
      REG_STATUS,
      REG_RSVD
   } region_e;

   function automatic region_e decode_region(input logic [31:0] addr,
                                             input int unsigned aw);
      logic [31:0] top;
      region_e     r;
      top = 32'(1) << aw;
      r   = REG_RAM;
      if (addr == top - 32'(CYCLE_OFS))       r = REG_CYCLE;
      else if (addr == top - 32'(TXDATA_OFS)) r = REG_TXDATA;
      else if (addr == top - 32'(STATUS_OFS)) r = REG_STATUS;
      else if (addr == top - 32'(RSVD_OFS))   r = REG_RSVD;
      return r;
   endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, otherwise it is dropped.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-port slave for the single-cycle core: word RAM plus four MMIO words at
// the top of the address space (cycle counter, TX FIFO push, status, reserved).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int SIZE       = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic [SIZE-1:0]       ddata_w,
   input  logic                  d_rw,
   output logic [SIZE-1:0]       ddata_r,
   output logic [SIZE-1:0]       tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);

   localparam int RAM_WORDS = (1 << ADDR_WIDTH) - 4;

   region_e         region;
   logic [SIZE-1:0] mem [RAM_WORDS];
   logic [SIZE-1:0] ram_rdata;
   logic [SIZE-1:0] cycle_cnt;
   logic [SIZE-1:0] status_word;
   logic            overflow;
   logic            fifo_full;
   logic            fifo_empty;
   logic            tx_push;
   logic            tx_pop;

   assign region = decode_region(32'(daddr), ADDR_WIDTH);

   always_ff @(posedge CLK) begin
      if (d_rw && region == REG_RAM) begin
         mem[daddr] <= ddata_w;
      end
   end

   assign ram_rdata = mem[daddr];

   // A clear write wins over the increment
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         cycle_cnt <= '0;
      end else if (d_rw && region == REG_CYCLE) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   // Stream handshake: tx_data transfers at a rising edge where tx_valid and
   // tx_ready are both high; tx_valid never depends on tx_ready.
   assign tx_valid = !fifo_empty;
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_push  = d_rw && region == REG_TXDATA;

   sync_fifo #(
      .WIDTH (SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .push      (tx_push),
      .push_data (ddata_w),
      .pop       (tx_pop),
      .head      (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         overflow <= 1'b0;
      end else if (tx_push && fifo_full && !tx_pop) begin
         overflow <= 1'b1;
      end else if (d_rw && region == REG_STATUS && ddata_w[ST_OVF]) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      status_word           = '0;
      status_word[ST_FULL]  = fifo_full;
      status_word[ST_EMPTY] = fifo_empty;
      status_word[ST_OVF]   = overflow;
   end

   always_comb begin
      ddata_r = '0;
      case (region)
         REG_RAM:    ddata_r = ram_rdata;
         REG_CYCLE:  ddata_r = cycle_cnt;
         REG_STATUS: ddata_r = status_word;
         default:    ddata_r = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a vector table for RAM/MMIO reads and writes, and
// hand-written FIFO, wrap and reset sequences checked through a TX scoreboard.
module tb_dmem_responder;

   localparam int SIZE  = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 4;

   localparam logic [AW-1:0] A_CYCLE = 10'd1020;
   localparam logic [AW-1:0] A_TX    = 10'd1021;
   localparam logic [AW-1:0] A_STAT  = 10'd1022;
   localparam logic [AW-1:0] A_RSVD  = 10'd1023;

   logic            CLK;
   logic            RESET_N;
   logic [AW-1:0]   daddr;
   logic [SIZE-1:0] ddata_w;
   logic            d_rw;
   logic [SIZE-1:0] ddata_r;
   logic [SIZE-1:0] tx_data;
   logic            tx_valid;
   logic            tx_ready;

   int checks   = 0;
   int failures = 0;

   logic [SIZE-1:0] exp_q[$];

   typedef struct {
      logic [AW-1:0]   addr;
      logic [SIZE-1:0] wdata;
      logic            rw;
      logic [SIZE-1:0] exp_rd;
      string           name;
   } vec_t;

   vec_t vecs[17];

   dmem_responder #(
      .SIZE       (SIZE),
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .daddr    (daddr),
      .ddata_w  (ddata_w),
      .d_rw     (d_rw),
      .ddata_r  (ddata_r),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [SIZE-1:0] act,
                        input logic [SIZE-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, then score the stream for the
   // coming rising edge and update the queue model.
   task automatic step(input logic [AW-1:0] a, input logic [SIZE-1:0] w,
                       input logic rw, input logic rdy, input logic rst_n);
      logic [SIZE-1:0] e;
      @(negedge CLK);
      daddr    = a;
      ddata_w  = w;
      d_rw     = rw;
      tx_ready = rdy;
      RESET_N  = rst_n;
      #1;
      if (rst_n) begin
         check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
         if (exp_q.size() != 0 && rdy) begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e);
         end
         if (rw && a == A_TX && exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
         end
      end else begin
         exp_q.delete();
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 12) begin
         step(A_STAT, 32'h0, 1'b0, 1'b1, 1'b1);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s: stream stalled, %0d entries left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      vecs[0]  = '{A_CYCLE, 32'h0,          1'b0, 32'd0,          "cycle_0"};
      vecs[1]  = '{A_CYCLE, 32'h0,          1'b0, 32'd1,          "cycle_1"};
      vecs[2]  = '{A_CYCLE, 32'h0,          1'b0, 32'd2,          "cycle_2"};
      vecs[3]  = '{A_CYCLE, 32'h1234,       1'b1, 32'd3,          "cycle_clr_old"};
      vecs[4]  = '{A_CYCLE, 32'h0,          1'b0, 32'd0,          "cycle_after_clr"};
      vecs[5]  = '{A_CYCLE, 32'h0,          1'b0, 32'd1,          "cycle_after_clr1"};
      vecs[6]  = '{10'd5,   32'hDEAD_BEEF,  1'b1, 32'h0,          "ram5_same_cycle"};
      vecs[7]  = '{10'd5,   32'h0,          1'b0, 32'hDEAD_BEEF,  "ram5_next"};
      vecs[8]  = '{10'd1019, 32'hA5A5_0001, 1'b1, 32'h0,          "ram_top_old"};
      vecs[9]  = '{10'd1019, 32'h0,         1'b0, 32'hA5A5_0001,  "ram_top_new"};
      vecs[10] = '{10'd0,   32'h0000_0777,  1'b1, 32'h0,          "ram0_old"};
      vecs[11] = '{10'd0,   32'h0,          1'b0, 32'h0000_0777,  "ram0_new"};
      vecs[12] = '{A_RSVD,  32'hFFFF_FFFF,  1'b1, 32'h0,          "rsvd_write"};
      vecs[13] = '{A_RSVD,  32'h0,          1'b0, 32'h0,          "rsvd_read"};
      vecs[14] = '{A_TX,    32'h0,          1'b0, 32'h0,          "txdata_read"};
      vecs[15] = '{A_STAT,  32'h0,          1'b0, 32'h2,          "status_idle"};
      vecs[16] = '{10'd1019, 32'h0,         1'b0, 32'hA5A5_0001,  "ram_top_keep"};

      RESET_N  = 1'b0;
      daddr    = '0;
      ddata_w  = '0;
      d_rw     = 1'b0;
      tx_ready = 1'b0;

      // reset: held for two edges, then checked while still asserted
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b0);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b0);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b0);
      check("reset_status", ddata_r, 32'h2);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);

      // table vectors: reset deasserts with the first one
      foreach (vecs[i]) begin
         step(vecs[i].addr, vecs[i].wdata, vecs[i].rw, 1'b0, 1'b1);
         check(vecs[i].name, ddata_r, vecs[i].exp_rd);
      end

      // fill, overflow, drain
      step(A_TX, 32'h11, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'h22, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'h33, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'h44, 1'b1, 1'b0, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_full", ddata_r, 32'h1);
      step(A_TX, 32'h55, 1'b1, 1'b0, 1'b1);
      check("txdata_read_on_push", ddata_r, 32'h0);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_ovf", ddata_r, 32'h5);
      drain("drain_ovf");
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_drained", ddata_r, 32'h6);
      check("tx_valid_drained", {31'b0, tx_valid}, 32'h0);

      // overflow clear: only bit2 clears it
      step(A_STAT, 32'h3, 1'b1, 1'b0, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_keep_ovf", ddata_r, 32'h6);
      step(A_STAT, 32'h4, 1'b1, 1'b0, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_ovf_clr", ddata_r, 32'h2);

      // push and pop in the same cycle while full
      step(A_TX, 32'hA1, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'hA2, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'hA3, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'hA4, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'h99, 1'b1, 1'b1, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_full_pushpop", ddata_r, 32'h1);
      drain("drain_pushpop");
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_after_pushpop", ddata_r, 32'h2);

      // counter wrap
      step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1);
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_cnt;
      check("cycle_forced", ddata_r, 32'hFFFF_FFFE);
      step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1);
      check("cycle_max", ddata_r, 32'hFFFF_FFFF);
      step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1);
      check("cycle_wrap", ddata_r, 32'h0);

      // reset mid-stream with a handshake offered in the reset cycle
      step(A_TX, 32'hB1, 1'b1, 1'b0, 1'b1);
      step(A_TX, 32'hB2, 1'b1, 1'b0, 1'b1);
      step(A_STAT, 32'h0, 1'b0, 1'b1, 1'b0);
      step(A_STAT, 32'h0, 1'b0, 1'b0, 1'b1);
      check("status_after_reset", ddata_r, 32'h2);
      check("tx_valid_after_reset", {31'b0, tx_valid}, 32'h0);
      step(10'd5, 32'h0, 1'b0, 1'b0, 1'b1);
      check("ram5_after_reset", ddata_r, 32'hDEAD_BEEF);
      step(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1);
      check("cycle_after_reset", ddata_r, 32'd2);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the slave end of the core's `daddr`/`ddata_w`/`ddata_r`/`d_rw` data port.
- Serves word loads and stores from an on-chip RAM.
- Decodes the top four word addresses as memory-mapped I/O: a free-running cycle counter, a debug transmit FIFO with a valid/ready output stream, and a status register.
- Sits beside the core in the top-level test harness; the instruction port is served separately.

## Interface
Parameters:
- `SIZE`, 32, data word width.
- `ADDR_WIDTH`, 10, word-address width; RAM holds 2^ADDR_WIDTH − 4 words.
- `FIFO_DEPTH`, 4, TX FIFO entries (power of two, ≥2).

Ports:
- `CLK` input 1, single clock; all state updates on rising edge.
- `RESET_N` input 1, reset is synchronous and active-low.
- `daddr` input ADDR_WIDTH, word address from core.
- `ddata_w` input SIZE, store data from core.
- `d_rw` input 1, 1 = store this cycle, 0 = no store (reads are always active).
- `ddata_r` output SIZE, load data, combinational from `daddr`.
- `tx_data` output SIZE, head of TX FIFO.
- `tx_valid` output 1, FIFO non-empty.
- `tx_ready` input 1, downstream accepts `tx_data` when `tx_valid & tx_ready` at a rising edge.

## Operation
Address map (word addresses, N = 2^ADDR_WIDTH):
- 0..N−5: RAM.
- N−4 `CYCLE`: read = counter value; write any data = clear counter.
- N−3 `TXDATA`: write = push `ddata_w` into FIFO; read returns 0.
- N−2 `STATUS`: read = {0…, overflow[2], empty[1], full[0]}; write with bit2=1 clears overflow, other bits ignored.
- N−1 `RSVD`: reads 0, writes ignored.

RAM:
- Store when `d_rw=1` and the address is in the RAM range.
- Not reset; simulation initial contents are 0.

Cycle counter:
- SIZE bits, +1 every cycle, wraps 2^SIZE−1 → 0.
- A clear write has priority over increment: counter = 0 after that edge, 1 after the next.

TX FIFO:
- Push on a `TXDATA` store; pop on `tx_valid & tx_ready`.
- Push when full without a pop in the same cycle: data dropped, sticky `overflow` set.
- Push and pop in the same cycle (FIFO non-empty): both occur, count unchanged; this includes the full case, which does not set overflow.
- Output order is strict FIFO; pointers wrap modulo FIFO_DEPTH.

Side effects:
- No read side effects; the core issues reads every cycle.

## Timing
- `ddata_r`: zero-latency combinational from `daddr` and current state.
- Read of an address being stored in the same cycle returns the old value; the new value is visible the cycle after the edge.
- Store latency: 1 edge.
- `tx_valid` rises the cycle after the first push into an empty FIFO.
- A pop takes effect at the edge; the next entry appears on `tx_data` immediately after that edge.
- `tx_data` is don't-care when `tx_valid=0`.

Reset (`RESET_N=0` sampled at an edge):
- counter = 0, FIFO empty, `tx_valid`=0, overflow = 0, RAM unchanged.
- `ddata_r` follows its combinational definition.
- Reset asserted mid-stream discards queued FIFO entries; a handshake in the reset cycle is ignored.

## Structure
- Package `dmem_pkg`:
  - MMIO offsets `CYCLE_OFS`=4, `TXDATA_OFS`=3, `STATUS_OFS`=2, `RSVD_OFS`=1 (counted from the top of the space).
  - Status bit indices `ST_FULL`=0, `ST_EMPTY`=1, `ST_OVF`=2.
- Sub-module `sync_fifo` #(WIDTH, DEPTH): push/pop/full/empty/head, synchronous active-low reset.
- Address decode, counter, RAM and status logic live in `dmem_responder`.

## Test plan
1. Store 0xDEADBEEF to word 5; read word 5 in the same cycle → old value 0; next cycle → 0xDEADBEEF.
2. After reset, read `CYCLE` for 3 consecutive cycles → 0, 1, 2; write `CYCLE` → reads 0 at the next cycle, 1 after.
3. With `tx_ready`=0, push 0x11, 0x22, 0x33, 0x44 → STATUS=0x1. Push 0x55 → STATUS=0x5. Raise `tx_ready` → stream 0x11, 0x22, 0x33, 0x44, then `tx_valid`=0 and STATUS=0x6.
4. FIFO full and `tx_ready`=1, push 0x99 in the same cycle → count stays 4, overflow stays 0, 0x99 emitted last.
5. Load counter to 2^SIZE−2 via force, run 2 cycles → reads 0xFFFFFFFF then 0; write STATUS=0x4 after overflow → bit2 clears.
6. Assert `RESET_N`=0 for one edge with 2 entries queued → `tx_valid`=0, STATUS=0x2, RAM word 5 still 0xDEADBEEF.
